// File: rtl/oled_msg_pkg.sv
// Shared types, message ids, ASCII constants and label strings for the OLED message sequencer.
// The CHANGE label only exists when OLED_MSG_CHANGE_EN is defined.
package oled_msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_EMIT,
    ST_WAIT_DONE
  } state_t;

  localparam logic [2:0] MSG_PRICE    = 3'd0;
  localparam logic [2:0] MSG_COIN     = 3'd1;
  localparam logic [2:0] MSG_TOTAL    = 3'd2;
  localparam logic [2:0] MSG_DISPENSE = 3'd3;
  localparam logic [2:0] MSG_CHANGE   = 3'd4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_C     = 8'h63;

  // Labels are stored space padded to the longest label so one indexer serves all.
  localparam int LABEL_LEN = 10;
  localparam logic [LABEL_LEN*8-1:0] LBL_PRICE    = "PRICE     ";
  localparam logic [LABEL_LEN*8-1:0] LBL_COIN     = "COIN      ";
  localparam logic [LABEL_LEN*8-1:0] LBL_TOTAL    = "TOTAL     ";
  localparam logic [LABEL_LEN*8-1:0] LBL_DISPENSE = "DISPENSING";
`ifdef OLED_MSG_CHANGE_EN
  localparam logic [LABEL_LEN*8-1:0] LBL_CHANGE   = "CHANGE    ";
`endif

  function automatic int label_field_w(input int chars, input int digits);
    return chars - digits - 1;
  endfunction

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Character idx (0 = leftmost) of the label for msg; spaces beyond the label.
  function automatic logic [7:0] label_char(input logic [2:0] msg, input int idx);
    logic [LABEL_LEN*8-1:0] s;
    logic [7:0]             c;
    s = {LABEL_LEN{ASCII_SPACE}};
    c = ASCII_SPACE;
    case (msg)
      MSG_PRICE:    s = LBL_PRICE;
      MSG_COIN:     s = LBL_COIN;
      MSG_TOTAL:    s = LBL_TOTAL;
      MSG_DISPENSE: s = LBL_DISPENSE;
`ifdef OLED_MSG_CHANGE_EN
      MSG_CHANGE:   s = LBL_CHANGE;
`endif
      default:      s = {LABEL_LEN{ASCII_SPACE}};
    endcase
    if (idx >= 0 && idx < LABEL_LEN) c = s[(LABEL_LEN-1-idx)*8 +: 8];
    return c;
  endfunction

endpackage

// File: rtl/oled_msg_seq_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, done pulses VAL_W cycles after start.
module bin2bcd_seq #(
  parameter int VAL_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [VAL_W-1:0]    value,
  output logic                done,
  output logic [DIGITS*4-1:0] bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [DIGITS*4-1:0] bcd_r;
  logic [DIGITS*4-1:0] adj;
  logic [VAL_W-1:0]    bin_r;
  logic [CNT_W-1:0]    cnt;
  logic                busy;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_r <= '0;
      bin_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      bcd_r <= '0;
      bin_r <= value;
      cnt   <= CNT_W'(VAL_W);
      busy  <= 1'b1;
    end else if (busy) begin
      {bcd_r, bin_r} <= {adj, bin_r} << 1;
      cnt            <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == CNT_W'(1));
  assign bcd  = bcd_r;

endmodule

// File: rtl/oled_msg_seq.sv
// Turns vending button events into fixed-width ASCII lines handed to the OLED writer.
// Define OLED_MSG_CHANGE_EN to follow each DISPENSE line with a CHANGE line.
module oled_msg_seq #(
  parameter int CHARS  = 12,
  parameter int VAL_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pb3,
  input  logic                 pb2,
  input  logic                 d,
  input  logic [VAL_W-1:0]     soda_val,
  input  logic [VAL_W-1:0]     cents_in,
  input  logic [VAL_W-1:0]     coins_val,
  input  logic                 char_done,
  output logic [CHARS*8-1:0]   line,
  output logic                 line_valid,
  output logic [2:0]           line_sel,
  output logic                 busy
);
  import oled_msg_pkg::*;

  localparam int FW = label_field_w(CHARS, DIGITS);

  if (pow10(DIGITS) <= (longint'(1) << VAL_W) - 1) begin : g_bad_digits
    $error("oled_msg_seq: DIGITS cannot represent the full VAL_W range");
  end
  if (CHARS < DIGITS + 9) begin : g_bad_chars
    $error("oled_msg_seq: CHARS must be at least DIGITS+9");
  end

  state_t state, next_state;
  logic [2:0] cur_msg, next_msg;

  logic prev_pb3, prev_pb2, prev_d;
  logic pend_pb3, pend_pb2, pend_d;
  logic req_pb3, req_pb2, req_d;
  logic take_pb3, take_pb2, take_d;
  logic pick;

  logic                conv_start;
  logic                conv_done;
  logic [VAL_W-1:0]    conv_value;
  logic [DIGITS*4-1:0] bcd;

  logic [CHARS*8-1:0] line_next;
  logic [7:0]         ch;
  logic [3:0]         dig;
  logic               seen;

`ifdef OLED_MSG_CHANGE_EN
  logic [VAL_W-1:0] change_val;
  assign change_val = (coins_val >= soda_val) ? (coins_val - soda_val) : '0;
`endif

  // An event is requested if it is already pending or its rising edge is seen this cycle.
  assign req_pb3 = pend_pb3 | (pb3 & ~prev_pb3);
  assign req_pb2 = pend_pb2 | (pb2 & ~prev_pb2);
  assign req_d   = pend_d   | (d   & ~prev_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cur_msg <= MSG_PRICE;
    end else begin
      state   <= next_state;
      cur_msg <= next_msg;
    end
  end

  always_comb begin
    next_state = state;
    next_msg   = cur_msg;
    take_pb3   = 1'b0;
    take_pb2   = 1'b0;
    take_d     = 1'b0;
    pick       = 1'b0;
    case (state)
      ST_IDLE: pick = 1'b1;
      ST_CONV: if (conv_done) next_state = ST_EMIT;
      ST_EMIT: next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (char_done) begin
          if (cur_msg == MSG_COIN) begin
            next_msg   = MSG_TOTAL;
            next_state = ST_CONV;
`ifdef OLED_MSG_CHANGE_EN
          end else if (cur_msg == MSG_DISPENSE) begin
            next_msg   = MSG_CHANGE;
            next_state = ST_CONV;
`endif
          end else begin
            pick = 1'b1;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (pick) begin
      if (req_d) begin
        next_msg   = MSG_DISPENSE;
        next_state = ST_EMIT;
        take_d     = 1'b1;
      end else if (req_pb2) begin
        next_msg   = MSG_COIN;
        next_state = ST_CONV;
        take_pb2   = 1'b1;
      end else if (req_pb3) begin
        next_msg   = MSG_PRICE;
        next_state = ST_CONV;
        take_pb3   = 1'b1;
      end else begin
        next_state = ST_IDLE;
      end
    end
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    conv_start = (next_state == ST_CONV) && (state != ST_CONV);
    conv_value = '0;
    case (next_msg)
      MSG_PRICE:  conv_value = soda_val;
      MSG_COIN:   conv_value = cents_in;
      MSG_TOTAL:  conv_value = coins_val;
`ifdef OLED_MSG_CHANGE_EN
      MSG_CHANGE: conv_value = change_val;
`endif
      default:    conv_value = '0;
    endcase
  end

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (conv_value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Pending bits survive until their message starts; repeated edges simply re-set them.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pb3 <= 1'b0;
      prev_pb2 <= 1'b0;
      prev_d   <= 1'b0;
      pend_pb3 <= 1'b0;
      pend_pb2 <= 1'b0;
      pend_d   <= 1'b0;
    end else begin
      prev_pb3 <= pb3;
      prev_pb2 <= pb2;
      prev_d   <= d;
      pend_pb3 <= req_pb3 & ~take_pb3;
      pend_pb2 <= req_pb2 & ~take_pb2;
      pend_d   <= req_d   & ~take_d;
    end
  end

  // Leading zeros blank until the first nonzero digit; the units digit always prints.
  always_comb begin
    line_next = {CHARS{ASCII_SPACE}};
    ch        = ASCII_SPACE;
    dig       = 4'd0;
    seen      = 1'b0;
    for (int k = 0; k < CHARS; k++) begin
      ch = ASCII_SPACE;
      if (cur_msg == MSG_DISPENSE || k < FW) begin
        ch = label_char(cur_msg, k);
      end else if (k < FW + DIGITS) begin
        dig = bcd[(FW+DIGITS-1-k)*4 +: 4];
        if (dig != 4'd0 || k == FW + DIGITS - 1) seen = 1'b1;
        ch = seen ? (ASCII_ZERO + {4'd0, dig}) : ASCII_SPACE;
      end else begin
        ch = ASCII_C;
      end
      line_next[(CHARS-1-k)*8 +: 8] = ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line       <= {CHARS{ASCII_SPACE}};
      line_valid <= 1'b0;
      line_sel   <= MSG_PRICE;
    end else if (state == ST_EMIT) begin
      line       <= line_next;
      line_sel   <= cur_msg;
      line_valid <= 1'b1;
    end else if (state == ST_WAIT_DONE && char_done) begin
      line_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oled_msg_seq.sv
// Self-checking bench for oled_msg_seq: expected lines are formatted from the display rules
// and queued per directed scenario; a negedge process compares every valid cycle.
module tb_oled_msg_seq;

  logic        clk;
  logic        rst;
  logic        pb3, pb2, d;
  logic [7:0]  soda_val, cents_in, coins_val;
  logic        char_done;
  logic [95:0] line;
  logic        line_valid;
  logic [2:0]  line_sel;
  logic        busy;

  typedef struct packed {
    logic [95:0] line;
    logic [2:0]  sel;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   ack_mode;

  oled_msg_seq #(.CHARS(12), .VAL_W(8), .DIGITS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .pb3        (pb3),
    .pb2        (pb2),
    .d          (d),
    .soda_val   (soda_val),
    .cents_in   (cents_in),
    .coins_val  (coins_val),
    .char_done  (char_done),
    .line       (line),
    .line_valid (line_valid),
    .line_sel   (line_sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] str2line(input string s);
    logic [95:0] v;
    for (int i = 0; i < 12; i++) v[(11-i)*8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return v;
  endfunction

  function automatic logic [95:0] mk_num(input string lbl, input int v);
    string s, n;
    s = lbl;
    while (s.len() < 8) s = {s, " "};
    n = $sformatf("%0d", v);
    while (n.len() < 3) n = {" ", n};
    return str2line({s, n, "c"});
  endfunction

  task automatic push_num(input string lbl, input int sel, input int v);
    exp_t e;
    e.line = mk_num(lbl, v);
    e.sel  = 3'(sel);
    q.push_back(e);
  endtask

  task automatic push_dispense(input int coins, input int price);
    exp_t e;
    e.line = str2line("DISPENSING");
    e.sel  = 3'd3;
    q.push_back(e);
`ifdef OLED_MSG_CHANGE_EN
    push_num("CHANGE", 4, (coins > price) ? coins - price : 0);
`endif
  endtask

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic p3, input logic p2, input logic dd);
    pb3 = p3;
    pb2 = p2;
    d   = dd;
    tick(1);
  endtask

  task automatic waitValid(input int max);
    for (int i = 0; i < max; i++) begin
      if (line_valid) break;
      tick(1);
    end
    checkOutput("wait_line_valid", {95'd0, line_valid}, 96'd1);
  endtask

  task automatic waitDrain(input int max);
    for (int i = 0; i < max; i++) begin
      if (q.size() == 0 && !busy && !line_valid) break;
      tick(1);
    end
    checkOutput("drain_remaining", 96'(q.size()), 96'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_line"}, line, {12{8'h20}});
    checkOutput({tag, "_valid"}, {95'd0, line_valid}, 96'd0);
    checkOutput({tag, "_sel"}, {93'd0, line_sel}, 96'd0);
    checkOutput({tag, "_busy"}, {95'd0, busy}, 96'd0);
  endtask

  // Writer model: 0 never acknowledges, 1 acknowledges each presented line, 2 holds char_done high.
  initial begin
    char_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        1:       char_done = line_valid;
        2:       char_done = 1'b1;
        default: char_done = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else if (line_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_line: got %s sel %0d expected no line", line, line_sel);
      end else begin
        checkOutput("line", line, q[0].line);
        checkOutput("line_sel", {93'd0, line_sel}, {93'd0, q[0].sel});
        if (char_done) void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; pb3 = 1'b0; pb2 = 1'b0; d = 1'b0;
    soda_val = 8'd0; cents_in = 8'd0; coins_val = 8'd0;
    ack_mode = 1;
    tick(3);
    checkReset("por");
    rst = 1'b0;
    tick(2);

    $display("[TB] price line and latency");
    soda_val = 8'd200;
    push_num("PRICE", 0, 200);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("price_busy", {95'd0, busy}, 96'd1);
    tick(8);
    checkOutput("price_valid_n9", {95'd0, line_valid}, 96'd0);
    tick(1);
    checkOutput("price_valid_n10", {95'd0, line_valid}, 96'd1);
    checkOutput("price_literal", line, "PRICE   200c");
    pb3 = 1'b0;
    waitDrain(100);

    $display("[TB] max value");
    soda_val = 8'd255;
    push_num("PRICE", 0, 255);
    applyStimulus(1'b1, 1'b0, 1'b0);
    pb3 = 1'b0;
    waitValid(30);
    checkOutput("max_literal", line, "PRICE   255c");
    waitDrain(100);

    $display("[TB] coin then total");
    cents_in = 8'd5; coins_val = 8'd75;
    push_num("COIN", 1, 5);
    push_num("TOTAL", 2, 75);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pb2 = 1'b0;
    waitValid(30);
    checkOutput("coin_literal", line, "COIN      5c");
    waitDrain(100);

    $display("[TB] reset during conversion");
    soda_val = 8'd200;
    push_num("PRICE", 0, 200);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(3);
    rst = 1'b1; pb3 = 1'b0;
    tick(1);
    checkReset("rst_conv");
    rst = 1'b0;
    tick(30);
    checkOutput("rst_conv_idle", {95'd0, busy}, 96'd0);

    $display("[TB] dispense with change");
    soda_val = 8'd200; coins_val = 8'd250;
    push_dispense(250, 200);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("disp_valid_n1", {95'd0, line_valid}, 96'd0);
    tick(1);
    checkOutput("disp_valid_n2", {95'd0, line_valid}, 96'd1);
    checkOutput("disp_literal", line, "DISPENSING  ");
    d = 1'b0;
    waitDrain(100);
    coins_val = 8'd150;
    push_dispense(150, 200);
    applyStimulus(1'b0, 1'b0, 1'b1);
    d = 1'b0;
    waitDrain(100);

    $display("[TB] simultaneous events");
    ack_mode = 0;
    soda_val = 8'd200; coins_val = 8'd250; cents_in = 8'd25;
    push_dispense(250, 200);
    push_num("COIN", 1, 25);
    push_num("TOTAL", 2, 250);
    push_num("PRICE", 0, 200);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitValid(10);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    ack_mode = 1;
    waitDrain(300);

    $display("[TB] held line with input changes and merged edges");
    ack_mode = 0;
    soda_val = 8'd100;
    push_num("PRICE", 0, 100);
    push_num("PRICE", 0, 7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValid(30);
    soda_val = 8'd7; cents_in = 8'd99; coins_val = 8'd1;
    for (int i = 0; i < 20; i++) begin
      pb3 = (i % 4) >= 2;
      tick(1);
    end
    pb3 = 1'b0;
    checkOutput("hold_valid", {95'd0, line_valid}, 96'd1);
    checkOutput("hold_literal", line, "PRICE   100c");
    ack_mode = 1;
    waitDrain(100);

    $display("[TB] char_done held high");
    ack_mode = 2;
    cents_in = 8'd10; coins_val = 8'd85;
    push_num("COIN", 1, 10);
    push_num("TOTAL", 2, 85);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pb2 = 1'b0;
    waitDrain(100);
    ack_mode = 1;
    tick(2);

    $display("[TB] reset during wait");
    ack_mode = 0;
    soda_val = 8'd200;
    push_num("PRICE", 0, 200);
    applyStimulus(1'b1, 1'b0, 1'b0);
    pb3 = 1'b0;
    waitValid(30);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1);
    checkReset("rst_wait");
    rst = 1'b0;
    ack_mode = 1;
    tick(40);
    checkOutput("rst_wait_idle", {95'd0, busy}, 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/oled_msg_seq.md
# oled_msg_seq

Parametrised successor to the soda-machine OLED controller. It turns vending events into fixed-width ASCII display lines and hands each line to the downstream character writer over a valid/done handshake. Events are price request, coin inserted, and dispense. Numeric fields use a shared sequential binary-to-BCD converter, and line width, value width and digit count are parameters. Events that arrive while the block is busy are queued rather than lost, and serviced in priority order. The block sits between the coin/price FSM and the OLED character writer.

## Interface
- `CHARS`, 12: characters per line; line bus width is `CHARS*8`.
- `VAL_W`, 8: width of the value inputs in bits.
- `DIGITS`, 3: decimal digits shown; must satisfy 10^DIGITS > 2^VAL_W-1 (elaboration check); `CHARS` ≥ `DIGITS`+9.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pb3` in 1: price request button, level; rising edge is the event.
- `pb2` in 1: coin-inserted button, level; rising edge is the event.
- `d` in 1: dispense request, level; rising edge is the event.
- `soda_val` in `VAL_W`: soda price in cents.
- `cents_in` in `VAL_W`: value of the last coin in cents.
- `coins_val` in `VAL_W`: running total inserted in cents.
- `char_done` in 1: writer has consumed the presented line.
- `line` out `CHARS*8`: ASCII line. Byte `CHARS-1` (MSBs) is the leftmost character.
- `line_valid` out 1: `line` is stable and awaiting `char_done`.
- `line_sel` out 3: message id: 0 PRICE, 1 COIN, 2 TOTAL, 3 DISPENSE, 4 CHANGE.
- `busy` out 1: state is not IDLE.

## Operation
- Edge detect: each button has a registered previous value. A rising edge sets that button's pending bit.
  - Pending bits clear only when their message is started.
  - Repeated edges while a bit is pending merge into one event.
- Priority when leaving IDLE: `d` > `pb2` > `pb3`.
- Message sequences per event:
  - `pb3`: PRICE.
  - `pb2`: COIN, then TOTAL.
  - `d`: DISPENSE, then CHANGE (CHANGE only if the macro below is defined).
- States: IDLE → CONV → EMIT → WAIT_DONE.
  - From WAIT_DONE: go to CONV for the next message of the same sequence.
  - Otherwise go to the next pending event's CONV, or IDLE.
  - DISPENSE has no numeric field and skips CONV (IDLE/WAIT_DONE → EMIT).
- CONV: value captured on entry. Double-dabble runs one bit per cycle for exactly `VAL_W` cycles.
  - PRICE uses `soda_val`; COIN uses `cents_in`; TOTAL uses `coins_val`.
  - CHANGE uses `coins_val - soda_val`, saturated to 0 when `coins_val < soda_val`.
- Line format: label left-justified in a field of `CHARS-DIGITS-1` characters, space padded, then `DIGITS` digits, then `c`.
  - Leading zeros become spaces; the units digit is always shown, so 0 displays as `0`.
  - Labels: `PRICE`, `COIN`, `TOTAL`, `CHANGE`.
  - DISPENSE line: `DISPENSING` left-justified, space padded, no value.
- EMIT: `line`, `line_sel` registered, `line_valid` set.
- WAIT_DONE: `line` and `line_valid` held until `char_done` is sampled high. `char_done` is ignored whenever `line_valid` is low.
- Input values are sampled only at CONV entry. Changes during conversion or wait do not affect the current line.
- `rst` mid-operation: returns to IDLE, clears pending bits and the converter, drops `line_valid` immediately. The previous button levels are loaded with 0, so a held button produces an edge one cycle after reset deasserts.

## Timing
- Reset values: `line` = all ASCII spaces (0x20), `line_valid` 0, `line_sel` 0, `busy` 0.
- Latency, edge sampled at cycle N while IDLE:
  - CONV occupies N+1 … N+`VAL_W`.
  - `line_valid` is high from cycle N+`VAL_W`+2.
  - DISPENSE: `line_valid` from N+2.
- `char_done` sampled high at cycle M: `line_valid` low at M+1. The next message's CONV starts at M+1.
- `char_done` held high continuously: each line still occupies at least one cycle with `line_valid` high.
- Simultaneous edges in one cycle: all latched and serviced in priority order, with no gap beyond the state sequence.

## Configuration
- `OLED_MSG_CHANGE_EN`
  - Defined: a `d` event emits DISPENSE then CHANGE.
  - Undefined: a `d` event emits DISPENSE only; the subtractor and CHANGE label are not compiled, and `line_sel` never equals 4.

## Structure
- Package `oled_msg_pkg`:
  - state enum;
  - message-id constants;
  - ASCII constants (space, `0`, `c`);
  - label strings;
  - the label-field-width function.
- Sub-module `bin2bcd_seq`:
  - parametrised by `VAL_W`/`DIGITS`;
  - `start` / `done` pulse interface;
  - done asserted `VAL_W` cycles after start;
  - reused by the other numeric display paths.

## Test plan
Defaults `CHARS`=12, `VAL_W`=8, `DIGITS`=3, macro defined.
- Price: `soda_val`=200, `pb3` rise → `line`=`PRICE   200c`, `line_sel` 0, `line_valid` at N+10.
- Coin: `cents_in`=5, `coins_val`=75, `pb2` rise, `char_done` pulsed per line → `COIN      5c`, then `TOTAL    75c`.
- Dispense: `soda_val`=200, `coins_val`=250, `d` rise → `DISPENSING  `, then `CHANGE   50c`. With `coins_val`=150 → `CHANGE    0c`. Macro undefined → DISPENSE only.
- Collision: `pb3` and `d` rise in the same cycle, plus a `pb2` rise during the first wait → order DISPENSE, CHANGE, COIN, TOTAL, PRICE; none lost.
- Hold: `char_done` low for 20 cycles with `line_valid` high → `line` stable; input changes ignored; a second `pb3` edge is merged.
- Reset: `rst` during CONV and during WAIT_DONE → next cycle all outputs at reset values, pending cleared. Max value 255 → `PRICE   255c`.
